mcp3008_interface: RTL and testbench

// - SPI master for one MCP3008 10-bit ADC. Runs command/readout frames on the ADC data clock.
// - Presents each result through a valid/accept handshake.
// - Sits between the ADC pins and the sample-processing logic.
// - Holding sample high gives back-to-back conversions.

---
 rtl/mcp3008_pkg.sv | 28 ++
 rtl/mcp3008_interface.sv | 128 ++++++++++++
 tb/tb_mcp3008_interface.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mcp3008_pkg.sv
// Shared types and frame constants for the MCP3008 SPI master.
// Used by mcp3008_interface.
package mcp3008_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    WAIT = 3'd2,
    DATA = 3'd3,
    GAP  = 3'd4
  } state_t;

  localparam int CNT_W        = 8;
  localparam int CMD_BITS     = 5;
  localparam int WAIT_BITS    = 2;
  localparam int DATA_BITS    = 10;
  localparam int RES_W        = 16;
  localparam int RES_CODE_LSB = 0;
  localparam int RES_CHAN_LSB = 10;
  localparam int RES_CHAN_W   = 3;

  // Result word: [15:13] zero, [12:10] channel, [9:0] ADC code.
  function automatic logic [RES_W-1:0] pack_result(input logic [RES_CHAN_W-1:0] chan,
                                                   input logic [DATA_BITS-1:0] code);
    return {3'b000, chan, code};
  endfunction

endpackage

// File: rtl/mcp3008_interface.sv
// SPI master for a single MCP3008 ADC with a valid/accept result handshake.
// Optional build macro MCP3008_CHANNEL_SCAN_EN: channel rotates 0..7 after every completed frame.
module mcp3008_interface
  import mcp3008_pkg::*;
#(
  parameter logic [2:0] CHANNEL        = 3'd0,
  parameter logic       SINGLE_ENDED   = 1'b1,
  parameter int         CS_HIGH_CYCLES = 2
) (
  input  logic        sample,
  input  logic        dclk,
  input  logic        dout,
  output logic        din,
  output logic        cs_n,
  output logic        busy,
  output logic [15:0] dout_reg,
  output logic        dout_avail,
  input  logic        dout_accept,
  input  logic        rst_n
);

  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [3:0]             r_cmd;
  logic [DATA_BITS-1:0]   r_shift;
  logic [RES_CHAN_W-1:0]  w_chan;
  logic                   w_start;
  logic                   w_frame_done;

  assign w_start      = sample && (!dout_avail || dout_accept);
  assign w_frame_done = (r_state == DATA) && (r_cnt == CNT_W'(DATA_BITS - 1));

`ifdef MCP3008_CHANNEL_SCAN_EN
  logic [RES_CHAN_W-1:0] r_chan;

  // Channel pointer advances once per completed conversion.
  always_ff @(posedge dclk or negedge rst_n) begin
    if (!rst_n) begin
      r_chan <= 3'd0;
    end else if (w_frame_done) begin
      r_chan <= r_chan + 3'd1;
    end
  end

  assign w_chan = r_chan;
`else
  assign w_chan = CHANNEL;
`endif

  // Frame sequencer; one counter walks CMD, WAIT, DATA and GAP.
  always_ff @(posedge dclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_cmd      <= 4'b0000;
      r_shift    <= '0;
      din        <= 1'b0;
      cs_n       <= 1'b1;
      busy       <= 1'b0;
      dout_reg   <= 16'h0000;
      dout_avail <= 1'b0;
    end else begin
      if (dout_avail && dout_accept) begin
        dout_avail <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (w_start) begin
            cs_n    <= 1'b0;
            din     <= 1'b1;
            busy    <= 1'b1;
            r_cmd   <= {SINGLE_ENDED, w_chan};
            r_cnt   <= '0;
            r_state <= CMD;
          end
        end
        CMD: begin
          // Shifting zeros in leaves din low once D0 has been presented.
          din   <= r_cmd[3];
          r_cmd <= {r_cmd[2:0], 1'b0};
          if (r_cnt == CNT_W'(CMD_BITS - 1)) begin
            r_cnt   <= '0;
            r_state <= WAIT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        WAIT: begin
          if (r_cnt == CNT_W'(WAIT_BITS - 1)) begin
            r_cnt   <= '0;
            r_state <= DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DATA: begin
          r_shift <= {r_shift[DATA_BITS-2:0], dout};
          if (w_frame_done) begin
            dout_reg   <= pack_result(w_chan, {r_shift[DATA_BITS-2:0], dout});
            dout_avail <= 1'b1;
            cs_n       <= 1'b1;
            r_cnt      <= '0;
            r_state    <= GAP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        GAP: begin
          if (r_cnt == CNT_W'(CS_HIGH_CYCLES - 1)) begin
            r_cnt   <= '0;
            busy    <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          din     <= 1'b0;
          cs_n    <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcp3008_interface.sv
// Directed bench for mcp3008_interface with a behavioural MCP3008 pin model.
// Build with MCP3008_CHANNEL_SCAN_EN defined to exercise the channel rotation.
module tb_mcp3008_interface;

  logic        dclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample = 1'b0;
  logic        dout = 1'b0;
  logic        dout_accept = 1'b0;
  logic        din;
  logic        cs_n;
  logic        busy;
  logic [15:0] dout_reg;
  logic        dout_avail;

  mcp3008_interface #(
    .CHANNEL       (3'd3),
    .SINGLE_ENDED  (1'b1),
    .CS_HIGH_CYCLES(2)
  ) dut (
    .sample     (sample),
    .dclk       (dclk),
    .dout       (dout),
    .din        (din),
    .cs_n       (cs_n),
    .busy       (busy),
    .dout_reg   (dout_reg),
    .dout_avail (dout_avail),
    .dout_accept(dout_accept),
    .rst_n      (rst_n)
  );

  always #5 dclk = ~dclk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [9:0] adc_code = 10'h000;
  logic [1:0] adc_stuck = 2'b00;
  int         adc_edges = 0;
  logic [4:0] cmd_seen = 5'b00000;
`ifdef MCP3008_CHANNEL_SCAN_EN
  logic [2:0] exp_chan = 3'd0;
`else
  logic [2:0] exp_chan = 3'd3;
`endif

  // ADC side: count edges since cs_n fell and capture the five command bits.
  always @(posedge dclk) begin
    if (cs_n) begin
      adc_edges <= 0;
    end else begin
      adc_edges <= adc_edges + 1;
      if (adc_edges < 5) cmd_seen <= {cmd_seen[3:0], din};
    end
  end

  // ADC side: B9..B0 driven on falling edges so the master sees them at S+8..S+17.
  always @(negedge dclk) begin
    if (adc_stuck[1])
      dout <= adc_stuck[0];
    else if (!cs_n && adc_edges >= 7 && adc_edges <= 16)
      dout <= adc_code[4'(16 - adc_edges)];
    else
      dout <= 1'b0;
  end

  typedef struct {
    logic [9:0]  code;
    logic [1:0]  stuck;
    logic [15:0] exp_reg;
  } vec_t;

  vec_t vecs[6];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %b required %b", name, act, exp);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_reg_of(input logic [15:0] tbl);
`ifdef MCP3008_CHANNEL_SCAN_EN
    return {tbl[15:13], exp_chan, tbl[9:0]};
`else
    return tbl;
`endif
  endfunction

  task automatic wait_avail(input int limit, output int lat);
    lat = -1;
    for (int i = 1; i <= limit; i++) begin
      @(posedge dclk); #1;
      if (dout_avail) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (!busy) break;
      @(posedge dclk); #1;
    end
    chk1("idle_reached", busy, 1'b0);
  endtask

  // Result and command bits of the frame that has just completed.
  task automatic check_frame(input string name, input logic [15:0] tbl_exp);
    chk16({name, "_dout_reg"}, dout_reg, exp_reg_of(tbl_exp));
    chk16({name, "_din_cmd"}, {11'b0, cmd_seen}, {11'b0, 2'b11, exp_chan});
`ifdef MCP3008_CHANNEL_SCAN_EN
    exp_chan = exp_chan + 3'd1;
`endif
  endtask

  task automatic one_shot(input string name, input vec_t v);
    int lat;
    @(negedge dclk);
    adc_code    = v.code;
    adc_stuck   = v.stuck;
    sample      = 1'b1;
    dout_accept = 1'b0;
    @(posedge dclk); #1;
    sample = 1'b0;
    chk1({name, "_cs_low"}, cs_n, 1'b0);
    chk1({name, "_busy"}, busy, 1'b1);
    wait_avail(30, lat);
    chk_int({name, "_latency"}, lat, 17);
    check_frame(name, v.exp_reg);
    @(negedge dclk);
    dout_accept = 1'b1;
    @(posedge dclk); #1;
    dout_accept = 1'b0;
    chk1({name, "_avail_clear"}, dout_avail, 1'b0);
    wait_idle(10);
    adc_stuck = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat;
    int bad;
    int gap;

    vecs[0] = '{10'h2A5, 2'b00, 16'h0EA5};
    vecs[1] = '{10'h3FF, 2'b11, 16'h0FFF};
    vecs[2] = '{10'h000, 2'b10, 16'h0C00};
    vecs[3] = '{10'h155, 2'b00, 16'h0D55};
    vecs[4] = '{10'h001, 2'b00, 16'h0C01};
    vecs[5] = '{10'h200, 2'b00, 16'h0E00};

    repeat (3) @(posedge dclk);
    #1;
    chk1("rst_cs_n", cs_n, 1'b1);
    chk1("rst_din", din, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_avail", dout_avail, 1'b0);
    chk16("rst_dout_reg", dout_reg, 16'h0000);
    @(negedge dclk);
    rst_n = 1'b1;

    dout_accept = 1'b1;
    repeat (2) @(posedge dclk);
    #1;
    chk1("stray_accept_avail", dout_avail, 1'b0);
    chk1("stray_accept_busy", busy, 1'b0);
    dout_accept = 1'b0;

    for (int k = 0; k < 6; k++) begin
      one_shot($sformatf("vec%0d", k), vecs[k]);
    end

    // Reset in the middle of the data phase.
    @(negedge dclk);
    adc_code = 10'h2A5;
    sample   = 1'b1;
    @(posedge dclk); #1;
    sample = 1'b0;
    repeat (12) @(posedge dclk);
    #1;
    rst_n = 1'b0;
    #1;
    chk1("midrst_cs_n", cs_n, 1'b1);
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_avail", dout_avail, 1'b0);
`ifdef MCP3008_CHANNEL_SCAN_EN
    exp_chan = 3'd0;
`endif
    @(negedge dclk);
    rst_n = 1'b1;
    one_shot("after_rst", vecs[0]);

    // Backpressure: result held, no new frame until accepted.
    @(negedge dclk);
    adc_code    = 10'h2A5;
    sample      = 1'b1;
    dout_accept = 1'b0;
    wait_avail(30, lat);
    chk_int("bp_latency", lat, 18);
    check_frame("bp", 16'h0EA5);
    repeat (4) @(posedge dclk);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge dclk); #1;
      if (busy || !cs_n || !dout_avail) bad++;
    end
    chk_int("bp_stalled", bad, 0);
    @(negedge dclk);
    dout_accept = 1'b1;
    @(posedge dclk); #1;
    chk1("bp_accept_clear", dout_avail, 1'b0);
    chk1("bp_restart_cs", cs_n, 1'b0);
    chk1("bp_restart_busy", busy, 1'b1);

    // Continuous conversions: period 20, one-cycle valid, two GAP cycles.
    for (int f = 0; f < 9; f++) begin
      wait_avail(30, lat);
      chk_int($sformatf("cont%0d_latency", f), lat, 17);
      check_frame($sformatf("cont%0d", f), 16'h0EA5);
      gap = (cs_n && busy) ? 1 : 0;
      for (int i = 0; i < 3; i++) begin
        @(posedge dclk); #1;
        if (i == 0) chk1($sformatf("cont%0d_pulse", f), dout_avail, 1'b0);
        if (cs_n && busy) gap++;
      end
      chk_int($sformatf("cont%0d_gap", f), gap, 2);
    end

    @(negedge dclk);
    sample      = 1'b0;
    dout_accept = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
